// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: captures decoded fields, scatters the immediate
// into the format's bit positions and emits the word with a sequential address.
module instr_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_load;
    logic        s1_advance;
    logic        out_fire;
    logic        is_shift;
    logic        enc_err;
    logic [31:0] enc_raw;
    logic [31:0] enc_word;
    logic signed [31:0] imm_s;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_fire   = out_valid && out_ready;

    assign imm_s    = $signed(s1_imm);
    assign is_shift = (s1_opcode == 7'b0010011) && (s1_funct3 == 3'b001 || s1_funct3 == 3'b101);

    always_comb begin
        enc_raw = '0;
        enc_err = 1'b0;
        case (s1_fmt)
            3'd0: enc_raw = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            3'd1: begin
                if (is_shift) begin
                    enc_raw = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                    // Unsigned compare also rejects negative shift amounts.
                    enc_err = s1_imm > 32'd31;
                end else begin
                    enc_raw = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                    enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
                end
            end
            3'd2: begin
                enc_raw = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
                enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            3'd3: begin
                enc_raw = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:1], s1_imm[11], s1_opcode};
                enc_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || s1_imm[0];
            end
            3'd4: begin
                enc_raw = {s1_imm[31:12], s1_rd, s1_opcode};
                enc_err = s1_imm[11:0] != 12'd0;
            end
            3'd5: begin
                enc_raw = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
                enc_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || s1_imm[0];
            end
            default: enc_err = 1'b1;
        endcase
        enc_word = enc_err ? Nop : enc_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt    <= fmt;
                    s1_opcode <= opcode;
                    s1_rd     <= rd;
                    s1_rs1    <= rs1;
                    s1_rs2    <= rs2;
                    s1_funct3 <= funct3;
                    s1_funct7 <= funct7;
                    s1_imm    <= imm;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= enc_word;
                    out_err   <= enc_err;
                end
            end
            if (out_fire) begin
                out_addr <= out_addr + ADDR_W'(4);
                if (out_err && err_count != 8'hff) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, pipeline corner sequences and random
// traffic scored against an arithmetic reference encoder.
module tb_instr_encoder;

    localparam logic [31:0] Base = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(Base)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_w;
        logic        exp_e;
    } vec_t;

    typedef struct packed {
        logic [31:0] w;
        logic        e;
    } sb_t;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    sb_t         sb[$];
    sb_t         cur;
    logic [31:0] m_addr = Base;
    int unsigned m_errcnt = 0;
    bit          last_infire;
    bit          stall_prev = 0;
    logic [31:0] held_instr, held_addr;
    vec_t        tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference encoder built from field positions with integer arithmetic.
    function automatic sb_t ref_enc(input vec_t v);
        longint x, r, w;
        sb_t    o;
        x = longint'($signed(v.imm));
        r = (longint'(v.rs1) << 15) | (longint'(v.f3) << 12);
        w = 0;
        o.e = 1'b0;
        case (v.fmt)
            3'd0: w = (longint'(v.f7) << 25) | (longint'(v.rs2) << 20) | r | (longint'(v.rd) << 7);
            3'd1: begin
                if (v.op == 7'h13 && (v.f3 == 3'd1 || v.f3 == 3'd5)) begin
                    o.e = x < 0 || x > 31;
                    w = (longint'(v.f7) << 25) | ((x & 31) << 20) | r | (longint'(v.rd) << 7);
                end else begin
                    o.e = x < -2048 || x > 2047;
                    w = ((x & 4095) << 20) | r | (longint'(v.rd) << 7);
                end
            end
            3'd2: begin
                o.e = x < -2048 || x > 2047;
                w = (((x >> 5) & 127) << 25) | (longint'(v.rs2) << 20) | r | ((x & 31) << 7);
            end
            3'd3: begin
                o.e = x < -4096 || x > 4094 || (x & 1) != 0;
                w = (((x >> 12) & 1) << 31) | (((x >> 5) & 63) << 25) | (longint'(v.rs2) << 20)
                    | r | (((x >> 1) & 15) << 8) | (((x >> 11) & 1) << 7);
            end
            3'd4: begin
                o.e = (x & 4095) != 0;
                w = (x & 64'h0000_0000_FFFF_F000) | (longint'(v.rd) << 7);
            end
            3'd5: begin
                o.e = x < -1048576 || x > 1048574 || (x & 1) != 0;
                w = (((x >> 20) & 1) << 31) | (((x >> 1) & 1023) << 21) | (((x >> 11) & 1) << 20)
                    | (((x >> 12) & 255) << 12) | (longint'(v.rd) << 7);
            end
            default: o.e = 1'b1;
        endcase
        o.w = o.e ? 32'h0000_0013 : (w[31:0] | {25'd0, v.op});
        return o;
    endfunction

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] ew, input logic ee);
        vec_t v;
        v.fmt = f; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7;
        v.imm = im; v.exp_w = ew; v.exp_e = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v, input sb_t e);
        fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; cur = e;
    endtask

    task automatic drive_tbl(input int i);
        sb_t e;
        e.w = tbl[i].exp_w;
        e.e = tbl[i].exp_e;
        drive(tbl[i], e);
    endtask

    // One clock: score handshakes seen before the edge, then advance to the next negedge.
    task automatic tick();
        sb_t e;
        #1;
        last_infire = in_valid && in_ready && !rst;
        if (rst) begin
            sb.delete();
            m_addr = Base;
            m_errcnt = 0;
            stall_prev = 0;
        end else begin
            check("err_count", {24'd0, err_count}, m_errcnt);
            if (stall_prev) begin
                check("stall_instr", out_instr, held_instr);
                check("stall_addr", out_addr, held_addr);
            end
            stall_prev = out_valid && !out_ready;
            held_instr = out_instr;
            held_addr = out_addr;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", out_instr, e.w);
                    check("out_err", {31'd0, out_err}, {31'd0, e.e});
                    check("out_addr", out_addr, m_addr);
                    m_addr = m_addr + 32'd4;
                    if (e.e && m_errcnt < 255) m_errcnt++;
                end
            end
            if (last_infire) sb.push_back(cur);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] bnd[17];
        bnd = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd31, 32'd32, 32'd0, -32'd1,
                32'd4094, 32'd4096, -32'd4096, -32'd4098, 32'd1048574, 32'd1048576,
                -32'd1048576, -32'd1048578, 32'h1234_5000};
        case ($urandom % 4)
            0: return bnd[$urandom % 17];
            1: return 32'($signed($urandom_range(0, 80)) - 40);
            2: return $urandom & 32'hFFFF_F000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        vec_t rv;
        tbl[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h0050_0093, 1'b0);
        tbl[1]  = mk(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3,          32'h4030_D093, 1'b0);
        tbl[2]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020_A423, 1'b0);
        tbl[3]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -32'd4,         32'hFE00_0EE3, 1'b0);
        tbl[4]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800,        32'h0010_00EF, 1'b0);
        tbl[5]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h0000_0013, 1'b1);
        tbl[6]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd6,          32'h0000_0363, 1'b0);
        tbl[7]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7,          32'h0000_0013, 1'b1);
        tbl[8]  = mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h0000_0013, 1'b1);
        tbl[9]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd99,         32'h0020_81B3, 1'b0);
        tbl[10] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        tbl[11] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001,  32'h0000_0013, 1'b1);
        tbl[12] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,    32'h0000_0013, 1'b1);
        tbl[13] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, -32'd2048,      32'h8000_0093, 1'b0);

        @(negedge clk);
        do_reset();
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_out_addr", out_addr, Base);
        check("rst_err_count", {24'd0, err_count}, 32'd0);

        // Latency: accepted in N, valid in N+2.
        out_ready = 1'b1;
        drive_tbl(0);
        in_valid = 1'b1;
        tick();
        check("lat_accept", {31'd0, last_infire}, 32'd1);
        in_valid = 1'b0;
        #1 check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        #1 check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Directed table, back-to-back with out_ready held high.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_tbl(i);
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Backpressure: only two words fit while stalled.
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            drive_tbl(k < 3 ? k : 2);
            in_valid = 1'b1;
            tick();
            if (last_infire) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 5 && k < 3; i++) begin
            tick();
            if (last_infire) k++;
        end
        check("bp_third_accepted", 32'(k), 32'd3);
        drain();
        check("bp_final_addr", out_addr, Base + 32'd12);

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_tbl(5 + i);
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_addr", out_addr, Base);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        drive_tbl(4);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        drain();

        // Saturation of err_count.
        do_reset();
        for (int i = 0; i < 262; i++) begin
            drive_tbl(8);
            in_valid = 1'b1;
            tick();
        end
        drain();
        check("err_sat", {24'd0, err_count}, 32'd255);

        // Random traffic against the reference encoder.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rv.fmt = 3'($urandom % 8);
            rv.op = ($urandom % 2 == 0) ? 7'h13 : 7'($urandom);
            rv.rd = 5'($urandom); rv.rs1 = 5'($urandom); rv.rs2 = 5'($urandom);
            rv.f3 = 3'($urandom); rv.f7 = 7'($urandom);
            rv.imm = rand_imm();
            rv.exp_w = '0; rv.exp_e = 1'b0;
            drive(rv, ref_enc(rv));
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
